thread_state_mgr: RTL and testbench
===================================

Name: thread_state_mgr

Overview:
- Per-thread state storage for the sha512crypt unit: one `THREAD_STATE_MSB+1`-bit entry per thread.
- Written by the CPU (port 1) and by the unit I/O side (port 2).
- Read asynchronously by the CPU thread scheduler (port 1) and by the I/O side (port 2).
- A round-robin scanner offers threads in `THREAD_STATE_RD_RDY` to the output stage through a valid/ack handshake.
- Sits directly upstream of the CPU thread-selection logic and supplies its ts_rd input.

Parameters:
N_CORES, 4, number of cores per unit
N_THREADS, 4*N_CORES, number of thread entries
N_THREADS_MSB, `MSB(N_THREADS-1), thread-number MSB

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-low reset
ts_wr_num1  in  N_THREADS_MSB+1  CPU write thread number
ts_wr1  in  `THREAD_STATE_MSB+1  CPU write state
ts_wr_en1  in  1  CPU write enable
ts_wr_num2  in  N_THREADS_MSB+1  I/O write thread number
ts_wr2  in  `THREAD_STATE_MSB+1  I/O write state
ts_wr_en2  in  1  I/O write enable
ts_rd_num1  in  N_THREADS_MSB+1  scheduler read address
ts_rd1  out  `THREAD_STATE_MSB+1  scheduler read data (combinational)
ts_rd_num2  in  N_THREADS_MSB+1  I/O read address
ts_rd2  out  `THREAD_STATE_MSB+1  I/O read data (combinational)
rd_rdy_valid  out  1  a RD_RDY thread is offered
rd_rdy_num  out  N_THREADS_MSB+1  offered thread number
rd_rdy_ack  in  1  output stage accepts offered thread
init_done  out  1  state memory initialised; writes accepted
wr_collision  out  1  sticky: both ports wrote the same thread in one cycle

Behaviour:
- Storage: N_THREADS-entry memory, 3 asynchronous read ports (rd1, rd2, scanner).
- Write pipeline:
  - Write requests are registered at edge E.
  - The memory is updated at edge E+1.
  - The new value appears on ts_rd1/ts_rd2 in the cycle after E+1: a 2-cycle write-to-read propagation. The scheduler's TS_DELAY=2 depends on this; it is fixed and must not change.
- Both ports writing different threads in the same cycle: both writes take effect.
- Both ports writing the same thread in the same cycle: port 1 wins and wr_collision is set. wr_collision clears only on reset.
- Reset, while RST_N=0:
  - init counter=0, init_done=0, rd_rdy_valid=0, rd_rdy_num=0, scan pointer=0, wr_collision=0.
  - Pending write pipeline registers are cleared.
- Init sweep after RST_N rises:
  - One entry per cycle is written `THREAD_STATE_NONE, entries 0..N_THREADS-1.
  - init_done goes to 1 on the edge that writes entry N_THREADS-1, i.e. N_THREADS cycles after release.
  - ts_wr_en1/2 are ignored while init_done=0.
  - Reasserting RST_N mid-sweep restarts the sweep from 0.
- Scanner FSM, states SCAN and OFFER:
  - SCAN (init_done=1):
    - Read entry[ptr].
    - If it is RD_RDY, register rd_rdy_num=ptr and rd_rdy_valid=1, and go to OFFER (ptr held).
    - Otherwise ptr advances, wrapping N_THREADS-1 -> 0.
  - OFFER:
    - rd_rdy_valid and rd_rdy_num are held stable until rd_rdy_ack=1.
    - On ack: rd_rdy_valid=0 next edge, ptr advances to rd_rdy_num+1 (wrapping), return to SCAN.
    - If a write (either port, registered stage) targets rd_rdy_num while offered and ack=0: withdraw the offer (valid=0 next edge), ptr advances, return to SCAN.
    - The same thread is never re-offered before the pointer wraps fully. This guarantees at least N_THREADS cycles for the consumer's state write to propagate.
  - rd_rdy_ack with rd_rdy_valid=0 is ignored.
- All outputs except ts_rd1/ts_rd2 are registered.

Test Plan:
- Reset: RST_N low 3 cycles, then high -> init_done=0 for 16 cycles (N_CORES=4), then 1; reading all 16 entries returns NONE; rd_rdy_valid=0 throughout.
- Propagation: CPU writes thread 5=WR_RDY at edge E -> ts_rd1(5) shows NONE in the cycle after E, WR_RDY in the cycle after E+1; same check via port 2 on ts_rd2.
- Collision: same cycle, port1 thread 3=BUSY, port2 thread 3=RD_RDY -> entry 3=BUSY, wr_collision=1 and stays 1; different threads 3/4 in the same cycle -> both written, wr_collision unchanged.
- Scanner: threads 2 and 9 set RD_RDY, ack held low -> rd_rdy_valid=1, num=2, held stable for 10 cycles; ack -> next offer num=9; ack plus I/O writes 2 and 9 to NONE -> no further offers.
- Withdraw: thread 7 offered, port1 writes thread 7=BUSY with ack=0 -> rd_rdy_valid=0 two edges later, and thread 7 is not re-offered.
- Reset mid-sweep and mid-offer: RST_N low during the sweep at entry 8 -> sweep restarts at 0 and init_done is delayed a full 16 cycles; RST_N low during OFFER -> rd_rdy_valid=0 next edge.

Source files
------------

// File: rtl/thread_state_mgr.sv
// Purpose: per-thread state memory for the sha512crypt unit with two write ports, two async read ports and a round-robin RD_RDY scanner.
// Latency: write registered at edge E, memory updated at E+1, new value readable the cycle after E+1; offers registered one edge after the scan hit.
// Backpressure: an offer is held stable until rd_rdy_ack; a write to the offered thread withdraws it instead.
//
// Ports:
//   CLK, RST_N                       clock, synchronous active-low reset
//   ts_wr_num1/ts_wr1/ts_wr_en1      CPU write (wins on same-thread collision)
//   ts_wr_num2/ts_wr2/ts_wr_en2      I/O write
//   ts_rd_num1 -> ts_rd1             scheduler read (combinational)
//   ts_rd_num2 -> ts_rd2             I/O read (combinational)
//   rd_rdy_valid/rd_rdy_num/ack      offer of a thread in RD_RDY state
//   init_done                        init sweep complete; writes accepted
//   wr_collision                     sticky: both ports hit the same thread in one cycle

`ifndef THREAD_STATE_MSB
`define THREAD_STATE_MSB 2
`endif
`ifndef THREAD_STATE_NONE
`define THREAD_STATE_NONE 3'd0
`endif
`ifndef THREAD_STATE_WR_RDY
`define THREAD_STATE_WR_RDY 3'd1
`endif
`ifndef THREAD_STATE_RD_RDY
`define THREAD_STATE_RD_RDY 3'd2
`endif
`ifndef THREAD_STATE_BUSY
`define THREAD_STATE_BUSY 3'd3
`endif
`ifndef MSB
`define MSB(x) ($clog2((x)+1)-1)
`endif

module thread_state_mgr #(
    parameter int N_CORES       = 4,
    parameter int N_THREADS     = 4*N_CORES,
    parameter int N_THREADS_MSB = `MSB(N_THREADS-1)
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [N_THREADS_MSB:0]       ts_wr_num1,
    input  logic [`THREAD_STATE_MSB:0]   ts_wr1,
    input  logic                         ts_wr_en1,
    input  logic [N_THREADS_MSB:0]       ts_wr_num2,
    input  logic [`THREAD_STATE_MSB:0]   ts_wr2,
    input  logic                         ts_wr_en2,
    input  logic [N_THREADS_MSB:0]       ts_rd_num1,
    output logic [`THREAD_STATE_MSB:0]   ts_rd1,
    input  logic [N_THREADS_MSB:0]       ts_rd_num2,
    output logic [`THREAD_STATE_MSB:0]   ts_rd2,
    output logic                         rd_rdy_valid,
    output logic [N_THREADS_MSB:0]       rd_rdy_num,
    input  logic                         rd_rdy_ack,
    output logic                         init_done,
    output logic                         wr_collision
);

    localparam int SW = `THREAD_STATE_MSB + 1;
    localparam int TW = N_THREADS_MSB + 1;

    typedef logic [TW-1:0] tnum_t;
    typedef logic [SW-1:0] tstate_t;
    typedef enum logic [0:0] {SCAN, OFFER} scan_state_t;

    localparam tnum_t LAST = tnum_t'(N_THREADS-1);

    function automatic tnum_t next_num(input tnum_t n);
        return (n == LAST) ? '0 : n + 1'b1;
    endfunction

    tstate_t     mem [N_THREADS];

    tnum_t       init_cnt;
    tnum_t       ptr;
    scan_state_t state;

    // Registered write stage: requests land here at edge E, memory at E+1.
    logic        wr_en1_q, wr_en2_q;
    tnum_t       wr_num1_q, wr_num2_q;
    tstate_t     wr_dat1_q, wr_dat2_q;

    logic        same_thread_q;
    logic        scan_hit;
    logic        withdraw;

    assign same_thread_q = wr_en1_q && wr_en2_q && (wr_num1_q == wr_num2_q);
    assign scan_hit      = (mem[ptr] == `THREAD_STATE_RD_RDY);
    // Only the registered stage is watched: a write there will hit memory next edge.
    assign withdraw      = (wr_en1_q && (wr_num1_q == rd_rdy_num)) ||
                           (wr_en2_q && (wr_num2_q == rd_rdy_num));

    assign ts_rd1 = mem[ts_rd_num1];
    assign ts_rd2 = mem[ts_rd_num2];

    // Storage has no reset; contents are defined by the init sweep.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (!init_done) begin
                mem[init_cnt] <= `THREAD_STATE_NONE;
            end else begin
                if (wr_en2_q && !same_thread_q)
                    mem[wr_num2_q] <= wr_dat2_q;
                if (wr_en1_q)
                    mem[wr_num1_q] <= wr_dat1_q;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            init_cnt     <= '0;
            init_done    <= 1'b0;
            wr_en1_q     <= 1'b0;
            wr_en2_q     <= 1'b0;
            wr_num1_q    <= '0;
            wr_num2_q    <= '0;
            wr_dat1_q    <= '0;
            wr_dat2_q    <= '0;
            wr_collision <= 1'b0;
            state        <= SCAN;
            ptr          <= '0;
            rd_rdy_valid <= 1'b0;
            rd_rdy_num   <= '0;
        end else begin
            if (!init_done) begin
                init_cnt <= next_num(init_cnt);
                if (init_cnt == LAST)
                    init_done <= 1'b1;
            end

            wr_en1_q  <= ts_wr_en1 && init_done;
            wr_en2_q  <= ts_wr_en2 && init_done;
            wr_num1_q <= ts_wr_num1;
            wr_num2_q <= ts_wr_num2;
            wr_dat1_q <= ts_wr1;
            wr_dat2_q <= ts_wr2;

            if (same_thread_q)
                wr_collision <= 1'b1;

            case (state)
                SCAN: begin
                    if (init_done) begin
                        if (scan_hit) begin
                            rd_rdy_num   <= ptr;
                            rd_rdy_valid <= 1'b1;
                            state        <= OFFER;
                        end else begin
                            ptr <= next_num(ptr);
                        end
                    end
                end
                OFFER: begin
                    // Pointer always moves past the offered thread, so it is not
                    // revisited until a full wrap; the consumer's write has time to land.
                    if (rd_rdy_ack) begin
                        rd_rdy_valid <= 1'b0;
                        ptr          <= next_num(rd_rdy_num);
                        state        <= SCAN;
                    end else if (withdraw) begin
                        rd_rdy_valid <= 1'b0;
                        ptr          <= next_num(ptr);
                        state        <= SCAN;
                    end
                end
                default: begin
                    state        <= SCAN;
                    rd_rdy_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thread_state_mgr.sv
// Bench for thread_state_mgr: directed stimulus pushes expected probes/offers into queues,
// a negedge monitor pops and compares them against the DUT outputs.

`ifndef THREAD_STATE_MSB
`define THREAD_STATE_MSB 2
`endif
`ifndef THREAD_STATE_NONE
`define THREAD_STATE_NONE 3'd0
`endif
`ifndef THREAD_STATE_WR_RDY
`define THREAD_STATE_WR_RDY 3'd1
`endif
`ifndef THREAD_STATE_RD_RDY
`define THREAD_STATE_RD_RDY 3'd2
`endif
`ifndef THREAD_STATE_BUSY
`define THREAD_STATE_BUSY 3'd3
`endif

module tb_thread_state_mgr;

    localparam int NT = 16;

    localparam int K_RD1   = 0;
    localparam int K_RD2   = 1;
    localparam int K_INIT  = 2;
    localparam int K_VALID = 3;
    localparam int K_NUM   = 4;
    localparam int K_COLL  = 5;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] ts_wr_num1, ts_wr_num2, ts_rd_num1, ts_rd_num2;
    logic [2:0] ts_wr1, ts_wr2, ts_rd1, ts_rd2;
    logic       ts_wr_en1, ts_wr_en2;
    logic       rd_rdy_valid, rd_rdy_ack;
    logic [3:0] rd_rdy_num;
    logic       init_done, wr_collision;

    always #5 CLK = ~CLK;

    thread_state_mgr #(.N_CORES(4)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .ts_wr_num1   (ts_wr_num1),
        .ts_wr1       (ts_wr1),
        .ts_wr_en1    (ts_wr_en1),
        .ts_wr_num2   (ts_wr_num2),
        .ts_wr2       (ts_wr2),
        .ts_wr_en2    (ts_wr_en2),
        .ts_rd_num1   (ts_rd_num1),
        .ts_rd1       (ts_rd1),
        .ts_rd_num2   (ts_rd_num2),
        .ts_rd2       (ts_rd2),
        .rd_rdy_valid (rd_rdy_valid),
        .rd_rdy_num   (rd_rdy_num),
        .rd_rdy_ack   (rd_rdy_ack),
        .init_done    (init_done),
        .wr_collision (wr_collision)
    );

    typedef struct {
        int         kind;
        logic [7:0] exp;
        string      name;
    } probe_t;

    probe_t probes[$];
    int     exp_offers[$];
    int     checks = 0;
    int     errors = 0;

    function automatic logic [7:0] actual(input int kind);
        case (kind)
            K_RD1:   return 8'(ts_rd1);
            K_RD2:   return 8'(ts_rd2);
            K_INIT:  return 8'(init_done);
            K_VALID: return 8'(rd_rdy_valid);
            K_NUM:   return 8'(rd_rdy_num);
            default: return 8'(wr_collision);
        endcase
    endfunction

    task automatic probe(input int kind, input logic [7:0] exp, input string name);
        probe_t p;
        p.kind = kind;
        p.exp  = exp;
        p.name = name;
        probes.push_back(p);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_offer(input string name);
        int n = 0;
        while (!rd_rdy_valid && n < 60) begin
            tick();
            n++;
        end
        if (!rd_rdy_valid) begin
            checks++;
            errors++;
            $display("FAIL %s: rd_rdy_valid=0 after 60 cycles, required 1", name);
        end
    endtask

    // Monitor: drains probes and checks every new offer against the expected-offer queue.
    initial begin
        probe_t     p;
        logic [7:0] act;
        logic       prev_valid;
        int         e;
        prev_valid = 1'b0;
        forever begin
            @(negedge CLK);
            while (probes.size() > 0) begin
                p   = probes.pop_front();
                act = actual(p.kind);
                checks++;
                if (act !== p.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h required %0h", p.name, act, p.exp);
                end
            end
            if (rd_rdy_valid === 1'b1 && !prev_valid) begin
                checks++;
                if (exp_offers.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_offer: got thread %0d required no offer", rd_rdy_num);
                end else begin
                    e = exp_offers.pop_front();
                    if (int'(rd_rdy_num) != e) begin
                        errors++;
                        $display("FAIL offer_num: got %0d required %0d", rd_rdy_num, e);
                    end
                end
            end
            prev_valid = (rd_rdy_valid === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal;
    end

    initial begin
        RST_N = 1'b0;
        ts_wr_num1 = '0; ts_wr1 = '0; ts_wr_en1 = 1'b0;
        ts_wr_num2 = '0; ts_wr2 = '0; ts_wr_en2 = 1'b0;
        ts_rd_num1 = '0; ts_rd_num2 = '0;
        rd_rdy_ack = 1'b0;

        // Reset and init sweep
        repeat (3) tick();
        probe(K_INIT, 0, "rst_init_done");
        probe(K_VALID, 0, "rst_valid");
        probe(K_COLL, 0, "rst_collision");
        RST_N = 1'b1;
        probe(K_INIT, 0, "sweep_init_0");
        for (int i = 1; i <= NT; i++) begin
            tick();
            probe(K_INIT, (i == NT) ? 8'd1 : 8'd0, "sweep_init");
            probe(K_VALID, 0, "sweep_valid");
        end
        for (int a = 0; a < NT; a++) begin
            ts_rd_num1 = 4'(a);
            ts_rd_num2 = 4'(NT-1-a);
            probe(K_RD1, `THREAD_STATE_NONE, "init_rd1");
            probe(K_RD2, `THREAD_STATE_NONE, "init_rd2");
            probe(K_VALID, 0, "init_valid");
            tick();
        end

        // Write-to-read propagation, port 1 then port 2
        ts_rd_num1 = 4'd5;
        ts_wr_num1 = 4'd5; ts_wr1 = `THREAD_STATE_WR_RDY; ts_wr_en1 = 1'b1;
        probe(K_RD1, `THREAD_STATE_NONE, "prop1_pre");
        tick(); ts_wr_en1 = 1'b0;
        probe(K_RD1, `THREAD_STATE_NONE, "prop1_after_E");
        tick();
        probe(K_RD1, `THREAD_STATE_WR_RDY, "prop1_after_E1");

        ts_rd_num2 = 4'd6;
        ts_wr_num2 = 4'd6; ts_wr2 = `THREAD_STATE_WR_RDY; ts_wr_en2 = 1'b1;
        tick(); ts_wr_en2 = 1'b0;
        probe(K_RD2, `THREAD_STATE_NONE, "prop2_after_E");
        tick();
        probe(K_RD2, `THREAD_STATE_WR_RDY, "prop2_after_E1");

        // Same-thread collision: port 1 wins
        ts_wr_num1 = 4'd3; ts_wr1 = `THREAD_STATE_BUSY;   ts_wr_en1 = 1'b1;
        ts_wr_num2 = 4'd3; ts_wr2 = `THREAD_STATE_RD_RDY; ts_wr_en2 = 1'b1;
        probe(K_COLL, 0, "coll_pre");
        tick(); ts_wr_en1 = 1'b0; ts_wr_en2 = 1'b0;
        tick();
        ts_rd_num1 = 4'd3;
        probe(K_RD1, `THREAD_STATE_BUSY, "coll_winner");
        probe(K_COLL, 1, "coll_set");
        repeat (3) begin
            tick();
            probe(K_COLL, 1, "coll_sticky");
        end

        // Different threads in the same cycle: both land
        ts_wr_num1 = 4'd3; ts_wr1 = `THREAD_STATE_WR_RDY; ts_wr_en1 = 1'b1;
        ts_wr_num2 = 4'd4; ts_wr2 = `THREAD_STATE_BUSY;   ts_wr_en2 = 1'b1;
        tick(); ts_wr_en1 = 1'b0; ts_wr_en2 = 1'b0;
        tick();
        ts_rd_num1 = 4'd3; ts_rd_num2 = 4'd4;
        probe(K_RD1, `THREAD_STATE_WR_RDY, "dual_wr_p1");
        probe(K_RD2, `THREAD_STATE_BUSY, "dual_wr_p2");
        probe(K_COLL, 1, "dual_wr_coll");
        tick();

        // Scanner: offer 2 held, then 9 after ack
        exp_offers.push_back(2);
        ts_wr_num1 = 4'd2; ts_wr1 = `THREAD_STATE_RD_RDY; ts_wr_en1 = 1'b1;
        tick(); ts_wr_en1 = 1'b0;
        wait_offer("offer2");
        exp_offers.push_back(9);
        ts_wr_num2 = 4'd9; ts_wr2 = `THREAD_STATE_RD_RDY; ts_wr_en2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            probe(K_VALID, 1, "hold_valid");
            probe(K_NUM, 2, "hold_num");
            tick();
            ts_wr_en2 = 1'b0;
        end
        rd_rdy_ack = 1'b1;
        probe(K_VALID, 1, "ack2_pre");
        tick(); rd_rdy_ack = 1'b0;
        probe(K_VALID, 0, "ack2_drop");
        wait_offer("offer9");
        probe(K_NUM, 9, "offer9_num");
        rd_rdy_ack = 1'b1;
        ts_wr_num2 = 4'd9; ts_wr2 = `THREAD_STATE_NONE; ts_wr_en2 = 1'b1;
        tick(); rd_rdy_ack = 1'b0;
        ts_wr_num2 = 4'd2; ts_wr2 = `THREAD_STATE_NONE; ts_wr_en2 = 1'b1;
        probe(K_VALID, 0, "ack9_drop");
        tick(); ts_wr_en2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            probe(K_VALID, 0, "no_more_offers");
            tick();
        end

        // Withdraw on write to the offered thread
        exp_offers.push_back(7);
        ts_wr_num1 = 4'd7; ts_wr1 = `THREAD_STATE_RD_RDY; ts_wr_en1 = 1'b1;
        tick(); ts_wr_en1 = 1'b0;
        wait_offer("offer7");
        ts_wr_num1 = 4'd7; ts_wr1 = `THREAD_STATE_BUSY; ts_wr_en1 = 1'b1;
        tick(); ts_wr_en1 = 1'b0;
        probe(K_VALID, 1, "withdraw_after_E");
        tick();
        probe(K_VALID, 0, "withdraw_after_E1");
        for (int i = 0; i < 40; i++) begin
            probe(K_VALID, 0, "no_reoffer7");
            tick();
        end
        ts_rd_num1 = 4'd7;
        probe(K_RD1, `THREAD_STATE_BUSY, "withdraw_state7");

        // Reset mid-sweep at entry 8
        RST_N = 1'b0;
        tick(); RST_N = 1'b1;
        probe(K_COLL, 0, "coll_cleared");
        for (int i = 0; i < 8; i++) begin
            tick();
            probe(K_INIT, 0, "midsweep_init");
        end
        RST_N = 1'b0;
        tick(); RST_N = 1'b1;
        probe(K_INIT, 0, "resweep_init_0");
        for (int i = 1; i <= NT; i++) begin
            tick();
            probe(K_INIT, (i == NT) ? 8'd1 : 8'd0, "resweep_init");
        end
        ts_rd_num1 = 4'd7; ts_rd_num2 = 4'd3;
        probe(K_RD1, `THREAD_STATE_NONE, "resweep_rd7");
        probe(K_RD2, `THREAD_STATE_NONE, "resweep_rd3");
        tick();

        // Reset during OFFER
        exp_offers.push_back(12);
        ts_wr_num1 = 4'd12; ts_wr1 = `THREAD_STATE_RD_RDY; ts_wr_en1 = 1'b1;
        tick(); ts_wr_en1 = 1'b0;
        wait_offer("offer12");
        RST_N = 1'b0;
        tick(); RST_N = 1'b1;
        probe(K_VALID, 0, "rst_offer_valid");
        probe(K_INIT, 0, "rst_offer_init");
        repeat (NT) tick();
        probe(K_INIT, 1, "rst_offer_init_done");
        for (int i = 0; i < 30; i++) begin
            probe(K_VALID, 0, "post_rst_no_offer");
            tick();
        end

        repeat (2) tick();
        checks++;
        if (exp_offers.size() != 0) begin
            errors++;
            $display("FAIL offers_left: got %0d pending offers required 0", exp_offers.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
